// File: rtl/sbqm_pkg.sv
// rtl/sbqm_pkg.sv - shared types and constants for the bank queue manager front end
package sbqm_pkg;

    localparam int OCC_W         = 3;
    localparam int MAX_COUNT_DEF = 7;
    localparam int TIMER_W       = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        UP_LOW   = 2'd1,
        DOWN_LOW = 2'd2,
        GAP      = 2'd3
    } sbqm_state_e;

endpackage

// File: rtl/sbqm_debounce.sv
// rtl/sbqm_debounce.sv - photocell synchroniser, debounce counter and rising-edge strobe
module sbqm_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_in,
    output logic rise
);

    logic       sync1_q, sync2_q;
    logic       level_q, level_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rise_q, rise_d;

    // Accept a level change only after DEBOUNCE_CYCLES consecutive differing samples;
    // the strobe marks the cycle after the debounced level goes high.
    always_comb begin
        level_d = level_q;
        cnt_d   = 4'd0;
        rise_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == 4'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
                rise_d  = ~level_q;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // Synchroniser and debounce state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= 4'd0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/sbqm_sensor_conditioner.sv
// rtl/sbqm_sensor_conditioner.sv - conditions entry/exit photocells into Counter up/down pulses (option: SBQM_STATS_EN)
module sbqm_sensor_conditioner
    import sbqm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 2,
    parameter int GAP_CYCLES      = 2,
    parameter int MAX_COUNT       = MAX_COUNT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             front_sensor,
    input  logic             back_sensor,
    output logic             upSignal,
    output logic             downSignal,
    output logic [OCC_W-1:0] occupancy,
    output logic             full,
    output logic             empty
`ifdef SBQM_STATS_EN
    ,
    output logic [7:0]       served_total,
    output logic             dropped_event
`endif
);

    logic up_rise, down_rise;

    sbqm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_front_db (
        .clk    (clk),
        .rst_n  (reset),
        .raw_in (front_sensor),
        .rise   (up_rise)
    );

    sbqm_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back_db (
        .clk    (clk),
        .rst_n  (reset),
        .raw_in (back_sensor),
        .rise   (down_rise)
    );

    sbqm_state_e        state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               up_pend_q, up_pend_d;
    logic               down_pend_q, down_pend_d;
    logic               up_n_q, up_n_d;
    logic               down_n_q, down_n_d;
    logic               decide;
    logic               at_full, at_empty;
`ifdef SBQM_STATS_EN
    logic [7:0]         served_q, served_d;
    logic               dropped_q, dropped_d;
`endif

    assign at_full  = (occ_q == OCC_W'(MAX_COUNT));
    assign at_empty = (occ_q == '0);

    // Pulse sequencer: the pending-event decision is taken in IDLE and also on the
    // last GAP cycle, so back-to-back pulses are separated by exactly GAP_CYCLES.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        occ_d       = occ_q;
        up_pend_d   = up_pend_q | up_rise;
        down_pend_d = down_pend_q | down_rise;
        decide      = 1'b0;
`ifdef SBQM_STATS_EN
        served_d    = served_q;
        dropped_d   = 1'b0;
`endif
        case (state_q)
            UP_LOW, DOWN_LOW: begin
                if (timer_q == TIMER_W'(PULSE_CYCLES - 1)) begin
                    state_d = GAP;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            GAP: begin
                if (timer_q == TIMER_W'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                    timer_d = '0;
                    decide  = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: decide = 1'b1;
        endcase

        if (decide) begin
            if (down_pend_q) begin
                down_pend_d = 1'b0;
                if (!at_empty) begin
                    state_d = DOWN_LOW;
                    timer_d = '0;
                    occ_d   = occ_q - OCC_W'(1);
`ifdef SBQM_STATS_EN
                    served_d = served_q + 8'd1;
`endif
                end
`ifdef SBQM_STATS_EN
                else begin
                    dropped_d = 1'b1;
                end
`endif
            end else if (up_pend_q) begin
                up_pend_d = 1'b0;
                if (!at_full) begin
                    state_d = UP_LOW;
                    timer_d = '0;
                    occ_d   = occ_q + OCC_W'(1);
                end
`ifdef SBQM_STATS_EN
                else begin
                    dropped_d = 1'b1;
                end
`endif
            end
        end

        up_n_d   = (state_d != UP_LOW);
        down_n_d = (state_d != DOWN_LOW);
    end

    // Sequencer state, shadow occupancy and glitch-free registered pulse outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            occ_q       <= '0;
            up_pend_q   <= 1'b0;
            down_pend_q <= 1'b0;
            up_n_q      <= 1'b1;
            down_n_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            occ_q       <= occ_d;
            up_pend_q   <= up_pend_d;
            down_pend_q <= down_pend_d;
            up_n_q      <= up_n_d;
            down_n_q    <= down_n_d;
        end
    end

`ifdef SBQM_STATS_EN
    // Served-customer count and dropped-event strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            served_q  <= 8'd0;
            dropped_q <= 1'b0;
        end else begin
            served_q  <= served_d;
            dropped_q <= dropped_d;
        end
    end

    assign served_total  = served_q;
    assign dropped_event = dropped_q;
`endif

    assign upSignal   = up_n_q;
    assign downSignal = down_n_q;
    assign occupancy  = occ_q;
    assign full       = at_full;
    assign empty      = at_empty;

endmodule

// File: tb/tb_sbqm_sensor_conditioner.sv
// tb/tb_sbqm_sensor_conditioner.sv - directed self-checking bench for sbqm_sensor_conditioner
module tb_sbqm_sensor_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic       front_sensor;
    logic       back_sensor;
    logic       upSignal;
    logic       downSignal;
    logic [2:0] occupancy;
    logic       full;
    logic       empty;

    sbqm_sensor_conditioner dut (
        .clk          (clk),
        .reset        (reset),
        .front_sensor (front_sensor),
        .back_sensor  (back_sensor),
        .upSignal     (upSignal),
        .downSignal   (downSignal),
        .occupancy    (occupancy),
        .full         (full),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    int   up_pulses   = 0;
    int   down_pulses = 0;
    int   overlap     = 0;
    logic up_prev     = 1'b1;
    logic down_prev   = 1'b1;

    always @(negedge clk) begin
        if (!upSignal && up_prev) up_pulses++;
        if (!downSignal && down_prev) down_pulses++;
        if (!upSignal && !downSignal) overlap++;
        up_prev   = upSignal;
        down_prev = downSignal;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(3);
        reset = 1'b1;
    endtask

    task automatic pulse_front();
        front_sensor = 1'b1;
        step(10);
        front_sensor = 1'b0;
        step(10);
    endtask

    task automatic pulse_back();
        back_sensor = 1'b1;
        step(10);
        back_sensor = 1'b0;
        step(10);
    endtask

    logic       up_hist   [1:16];
    logic       down_hist [1:16];
    logic [2:0] occ_hist  [1:16];
    int         snap_up, snap_down;
    logic [2:0] occ_peak;

    initial begin
        reset        = 1'b0;
        front_sensor = 1'b0;
        back_sensor  = 1'b0;
        step(3);
        check("rst_up", upSignal, 1);
        check("rst_down", downSignal, 1);
        check("rst_occ", occupancy, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);

        // First arrival, front held high from reset release.
        front_sensor = 1'b1;
        reset        = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(posedge clk);
            #1;
            up_hist[e] = upSignal;
        end
        front_sensor = 1'b0;
        check("lat_up_e7", up_hist[7], 1);
        check("lat_up_e8", up_hist[8], 0);
        check("lat_up_e9", up_hist[9], 0);
        check("lat_up_e10", up_hist[10], 1);
        step(10);
        check("first_occ", occupancy, 1);
        check("first_empty", empty, 0);
        check("first_pulses", up_pulses, 1);

        // Short glitch must not qualify.
        snap_up      = up_pulses;
        front_sensor = 1'b1;
        step(3);
        front_sensor = 1'b0;
        step(15);
        check("glitch_pulses", up_pulses - snap_up, 0);
        check("glitch_occ", occupancy, 1);

        // Fill to capacity; the eighth arrival is dropped.
        do_reset();
        snap_up = up_pulses;
        for (int i = 0; i < 8; i++) pulse_front();
        check("fill_pulses", up_pulses - snap_up, 7);
        check("fill_occ", occupancy, 7);
        check("fill_full", full, 1);
        check("fill_empty", empty, 0);

        // Drain down to three.
        snap_down = down_pulses;
        for (int i = 0; i < 4; i++) pulse_back();
        check("drain_pulses", down_pulses - snap_down, 4);
        check("drain_occ", occupancy, 3);
        check("drain_full", full, 0);

        // Simultaneous entry and exit: down first, gap, then up.
        front_sensor = 1'b1;
        back_sensor  = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk);
            #1;
            up_hist[e]   = upSignal;
            down_hist[e] = downSignal;
            occ_hist[e]  = occupancy;
        end
        front_sensor = 1'b0;
        back_sensor  = 1'b0;
        occ_peak = 3'd0;
        for (int e = 1; e <= 16; e++) if (occ_hist[e] > occ_peak) occ_peak = occ_hist[e];
        check("both_down_e7", down_hist[7], 1);
        check("both_down_e8", down_hist[8], 0);
        check("both_down_e9", down_hist[9], 0);
        check("both_down_e10", down_hist[10], 1);
        check("both_up_e11", up_hist[11], 1);
        check("both_up_e12", up_hist[12], 0);
        check("both_up_e13", up_hist[13], 0);
        check("both_up_e14", up_hist[14], 1);
        check("both_occ_e8", occ_hist[8], 2);
        check("both_occ_end", occ_hist[16], 3);
        check("both_occ_peak", occ_peak, 3);
        step(12);

        // Exit at empty queue is dropped.
        do_reset();
        snap_down = down_pulses;
        pulse_back();
        check("empty_down_pulses", down_pulses - snap_down, 0);
        check("empty_flag", empty, 1);
        check("empty_occ", occupancy, 0);

        // Reset during the first low cycle of an up pulse.
        do_reset();
        front_sensor = 1'b1;
        step(8);
        check("midrst_low", upSignal, 0);
        check("midrst_occ_pre", occupancy, 1);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_up", upSignal, 1);
        check("midrst_occ", occupancy, 0);
        front_sensor = 1'b0;
        snap_up = up_pulses;
        step(3);
        reset = 1'b1;
        step(25);
        check("midrst_no_residual", up_pulses - snap_up, 0);
        check("midrst_occ_after", occupancy, 0);

        check("never_both_low", overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
